// File: rtl/ifq_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package ifq_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } ifq_entry_t;

  localparam int unsigned IFQ_DEPTH_DEF      = 4;
  localparam logic [31:0] IFQ_RESET_ADDR_DEF = 32'h0000_0000;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous entry FIFO with flush, occupancy count and same-cycle push/pop (also when full).
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH     = IFQ_DEPTH_DEF,
  parameter ifq_entry_t  RST_ENTRY = '0
) (
  input  logic                     clk_i,
  input  logic                     resetb_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  ifq_entry_t               data_i,
  input  logic                     pop_i,
  output ifq_entry_t               head_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  ifq_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != FULL_CNT) || do_pop);

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= RST_ENTRY;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: credit-limited request issue, response tagging with PC,
// stale-response dropping after redirects, and a registered instruction queue.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH      = IFQ_DEPTH_DEF,
  parameter logic [31:0] RESET_ADDR = IFQ_RESET_ADDR_DEF
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        jump_valid,
  input  logic [31:0] jump_addr,
  input  logic [1:0]  priv,
  input  logic        treqready,
  output logic        treqvalid,
  output logic [1:0]  treqpriv,
  output logic [31:0] treqaddr,
  output logic        trspready,
  input  logic        trspvalid,
  input  logic        trsprerr,
  input  logic [31:0] trspdata,
  output logic        ivalid,
  input  logic        iready,
  output logic [31:0] ipc,
  output logic [31:0] iinstr,
  output logic        ierr
);

  localparam int unsigned CW        = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_LIM = (CW+1)'(DEPTH);
  localparam logic [31:0] RST_PC    = RESET_ADDR & ~32'h3;
  localparam ifq_entry_t  RST_ENTRY = '{pc: RST_PC, instr: '0, err: 1'b0};

  logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, jump_tgt;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, fifo_count;
  logic          req_xfer, rsp_take, rsp_keep, fifo_empty, deq;
  ifq_entry_t    push_entry, head;

  assign jump_tgt  = jump_addr & ~32'h3;
  assign treqvalid = resetb && !jump_valid &&
                     (({1'b0, out_q} + {1'b0, fifo_count}) < DEPTH_LIM);
  assign treqaddr  = fetch_pc_q;
  assign treqpriv  = priv;
  assign trspready = resetb;

  assign req_xfer = treqvalid && treqready;
  // Responses with nothing outstanding are leftovers from before a reset.
  assign rsp_take = trspvalid && (out_q != '0);
  assign rsp_keep = rsp_take && (drop_q == '0) && !jump_valid;
  assign deq      = ivalid && iready && !jump_valid;

  assign push_entry = '{pc: rsp_pc_q, instr: trspdata, err: trsprerr};

  always_comb begin
    out_d      = out_q;
    drop_d     = drop_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;

    case ({req_xfer, rsp_take})
      2'b10:   out_d = out_q + CW'(1);
      2'b01:   out_d = out_q - CW'(1);
      default: out_d = out_q;
    endcase

    if (jump_valid) begin
      drop_d     = out_q - CW'(rsp_take);
      fetch_pc_d = jump_tgt;
      rsp_pc_d   = jump_tgt;
    end else begin
      if (rsp_take && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (req_xfer) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_keep) rsp_pc_d   = rsp_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      out_q      <= '0;
      drop_q     <= '0;
      fetch_pc_q <= RST_PC;
      rsp_pc_q   <= RST_PC;
    end else begin
      out_q      <= out_d;
      drop_q     <= drop_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
    end
  end

  ifq_fifo #(
    .DEPTH     (DEPTH),
    .RST_ENTRY (RST_ENTRY)
  ) u_fifo (
    .clk_i    (clk),
    .resetb_i (resetb),
    .flush_i  (jump_valid),
    .push_i   (rsp_keep),
    .data_i   (push_entry),
    .pop_i    (deq),
    .head_o   (head),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  assign ivalid = !fifo_empty;
  assign ipc    = head.pc;
  assign iinstr = head.instr;
  assign ierr   = head.err;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a 1-cycle instruction-port responder and delivery log.
module tb_ifetch_queue;

  localparam int unsigned DEPTH      = 4;
  localparam logic [31:0] RESET_ADDR = 32'h0;

  logic        clk = 1'b0, resetb = 1'b0;
  logic        jump_valid = 1'b0, treqready = 1'b0, trspvalid = 1'b0, trsprerr = 1'b0, iready = 1'b0;
  logic [31:0] jump_addr = '0, trspdata = '0;
  logic [1:0]  priv = 2'b00;
  logic        treqvalid, trspready, ivalid, ierr;
  logic [1:0]  treqpriv;
  logic [31:0] treqaddr, ipc, iinstr;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_ADDR(RESET_ADDR)) dut (
    .clk(clk), .resetb(resetb), .jump_valid(jump_valid), .jump_addr(jump_addr), .priv(priv),
    .treqready(treqready), .treqvalid(treqvalid), .treqpriv(treqpriv), .treqaddr(treqaddr),
    .trspready(trspready), .trspvalid(trspvalid), .trsprerr(trsprerr), .trspdata(trspdata),
    .ivalid(ivalid), .iready(iready), .ipc(ipc), .iinstr(iinstr), .ierr(ierr)
  );

  int          n_checks = 0, n_fail = 0, cyc = 0;
  logic [31:0] pend[$], rq[$], dq_pc[$], dq_instr[$];
  logic        dq_err[$];
  int          dq_cyc[$];
  bit          rsp_en, rand_ready, rand_iready, inject_stray, last_treqvalid;
  logic [31:0] err_addr = '1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Called at posedge+1: drive this cycle's inputs, sample at +2, then advance one clock.
  task automatic step(input logic jv = 1'b0, input logic [31:0] ja = '0);
    logic [31:0] a;
    jump_valid = jv;
    jump_addr  = ja;
    if (inject_stray) begin
      trspvalid = 1'b1; trspdata = 32'hDEAD_BEEF; trsprerr = 1'b0;
    end else if (rsp_en && pend.size() > 0) begin
      a = pend.pop_front();
      trspvalid = 1'b1; trspdata = mem_word(a); trsprerr = (a == err_addr);
    end else begin
      trspvalid = 1'b0; trspdata = '0; trsprerr = 1'b0;
    end
    if (rand_ready)  treqready = 1'($urandom_range(0, 1));
    if (rand_iready) iready    = 1'($urandom_range(0, 1));
    #1;
    last_treqvalid = treqvalid;
    if (treqvalid && treqready) begin
      pend.push_back(treqaddr);
      rq.push_back(treqaddr);
    end
    if (ivalid && iready && !jv) begin
      dq_pc.push_back(ipc); dq_instr.push_back(iinstr); dq_err.push_back(ierr); dq_cyc.push_back(cyc);
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic clear_logs();
    pend.delete(); rq.delete(); dq_pc.delete(); dq_instr.delete(); dq_err.delete(); dq_cyc.delete();
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    resetb = 1'b0; jump_valid = 1'b0; trspvalid = 1'b0; trsprerr = 1'b0; trspdata = '0;
    rsp_en = 1'b1; rand_ready = 1'b0; rand_iready = 1'b0; inject_stray = 1'b0; err_addr = '1;
    iready = 1'b1; treqready = 1'b1;
    clear_logs();
    repeat (2) @(posedge clk);
    #1;
    resetb = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    treqready = 1'b1; iready = 1'b1; trspvalid = 1'b1; trspdata = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (treqvalid !== 1'b0) begin n_fail++; $display("FAIL reset_treqvalid: got %b expected 0", treqvalid); end
    n_checks++; if (trspready !== 1'b0) begin n_fail++; $display("FAIL reset_trspready: got %b expected 0", trspready); end
    n_checks++; if (ivalid !== 1'b0) begin n_fail++; $display("FAIL reset_ivalid: got %b expected 0", ivalid); end
    n_checks++; if (treqaddr !== RESET_ADDR) begin n_fail++; $display("FAIL reset_treqaddr: got %h expected %h", treqaddr, RESET_ADDR); end
    n_checks++; if (ipc !== RESET_ADDR) begin n_fail++; $display("FAIL reset_ipc: got %h expected %h", ipc, RESET_ADDR); end
    n_checks++; if (iinstr !== 32'h0) begin n_fail++; $display("FAIL reset_iinstr: got %h expected 0", iinstr); end
    n_checks++; if (ierr !== 1'b0) begin n_fail++; $display("FAIL reset_ierr: got %b expected 0", ierr); end
    trspvalid = 1'b0;
    resetb = 1'b1;
    #1;
    n_checks++; if (treqvalid !== 1'b1) begin n_fail++; $display("FAIL release_treqvalid: got %b expected 1", treqvalid); end
    n_checks++; if (trspready !== 1'b1) begin n_fail++; $display("FAIL release_trspready: got %b expected 1", trspready); end
  endtask

  task automatic test_stream();
    apply_reset();
    priv = 2'b11;
    repeat (10) step();
    n_checks++; if (rq.size() !== 10) begin n_fail++; $display("FAIL stream_req_count: got %0d expected 10", rq.size()); end
    for (int i = 0; i < rq.size(); i++) begin
      n_checks++; if (rq[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_treqaddr[%0d]: got %h expected %h", i, rq[i], 32'(4 * i)); end
    end
    n_checks++; if (dq_pc.size() !== 8) begin n_fail++; $display("FAIL stream_deliv_count: got %0d expected 8", dq_pc.size()); end
    for (int i = 0; i < dq_pc.size(); i++) begin
      n_checks++; if (dq_pc[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_ipc[%0d]: got %h expected %h", i, dq_pc[i], 32'(4 * i)); end
      n_checks++; if (dq_instr[i] !== mem_word(32'(4 * i))) begin n_fail++; $display("FAIL stream_iinstr[%0d]: got %h expected %h", i, dq_instr[i], mem_word(32'(4 * i))); end
      n_checks++; if (dq_cyc[i] !== 2 + i) begin n_fail++; $display("FAIL stream_cycle[%0d]: got %0d expected %0d", i, dq_cyc[i], 2 + i); end
    end
    n_checks++; if (treqpriv !== 2'b11) begin n_fail++; $display("FAIL treqpriv_11: got %b expected 11", treqpriv); end
    priv = 2'b01;
    #1;
    n_checks++; if (treqpriv !== 2'b01) begin n_fail++; $display("FAIL treqpriv_01: got %b expected 01", treqpriv); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    iready = 1'b0;
    repeat (8) step();
    n_checks++; if (rq.size() !== 4) begin n_fail++; $display("FAIL bp_req_count: got %0d expected 4", rq.size()); end
    n_checks++; if (last_treqvalid !== 1'b0) begin n_fail++; $display("FAIL bp_treqvalid: got %b expected 0", last_treqvalid); end
    n_checks++; if (ivalid !== 1'b1) begin n_fail++; $display("FAIL bp_ivalid: got %b expected 1", ivalid); end
    n_checks++; if (dq_pc.size() !== 0) begin n_fail++; $display("FAIL bp_no_deliv: got %0d expected 0", dq_pc.size()); end
    iready = 1'b1;
    repeat (14) step();
    n_checks++; if (dq_pc.size() < 12) begin n_fail++; $display("FAIL bp_resume_count: got %0d expected >=12", dq_pc.size()); end
    for (int i = 0; i < dq_pc.size(); i++) begin
      n_checks++; if (dq_pc[i] !== 32'(4 * i) || dq_instr[i] !== mem_word(32'(4 * i))) begin
        n_fail++; $display("FAIL bp_entry[%0d]: got pc %h instr %h expected pc %h instr %h", i, dq_pc[i], dq_instr[i], 32'(4 * i), mem_word(32'(4 * i)));
      end
      if (i > 0) begin
        n_checks++; if (dq_cyc[i] !== dq_cyc[i-1] + 1) begin n_fail++; $display("FAIL bp_rate[%0d]: got cycle %0d expected %0d", i, dq_cyc[i], dq_cyc[i-1] + 1); end
      end
    end
  endtask

  task automatic test_jump();
    int nrq;
    apply_reset();
    iready = 1'b0;
    repeat (2) step();
    rsp_en = 1'b0;
    step();
    n_checks++; if (ivalid !== 1'b1) begin n_fail++; $display("FAIL jump_pre_ivalid: got %b expected 1", ivalid); end
    nrq = rq.size();
    step(1'b1, 32'h0000_0103);
    n_checks++; if (last_treqvalid !== 1'b0) begin n_fail++; $display("FAIL jump_treqvalid: got %b expected 0", last_treqvalid); end
    n_checks++; if (ivalid !== 1'b0) begin n_fail++; $display("FAIL jump_flush_ivalid: got %b expected 0", ivalid); end
    n_checks++; if (treqaddr !== 32'h100) begin n_fail++; $display("FAIL jump_treqaddr: got %h expected 00000100", treqaddr); end
    rsp_en = 1'b1; iready = 1'b1;
    dq_pc.delete(); dq_instr.delete(); dq_err.delete(); dq_cyc.delete();
    repeat (10) step();
    n_checks++; if (rq.size() <= nrq || rq[nrq] !== 32'h100) begin n_fail++; $display("FAIL jump_first_req: got %0d reqs, expected next req 00000100", rq.size() - nrq); end
    n_checks++; if (dq_pc.size() < 4) begin n_fail++; $display("FAIL jump_deliv_count: got %0d expected >=4", dq_pc.size()); end
    for (int i = 0; i < dq_pc.size(); i++) begin
      n_checks++; if (dq_pc[i] !== 32'h100 + 32'(4 * i) || dq_instr[i] !== mem_word(32'h100 + 32'(4 * i))) begin
        n_fail++; $display("FAIL jump_entry[%0d]: got pc %h instr %h expected pc %h", i, dq_pc[i], dq_instr[i], 32'h100 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_back_to_back_jump();
    int nrq;
    apply_reset();
    repeat (3) step();
    dq_pc.delete(); dq_instr.delete(); dq_err.delete(); dq_cyc.delete();
    nrq = rq.size();
    step(1'b1, 32'h0000_0180);
    step(1'b1, 32'h0000_0200);
    repeat (10) step();
    n_checks++; if (rq.size() <= nrq || rq[nrq] !== 32'h200) begin n_fail++; $display("FAIL b2b_first_req: got %0d reqs, expected next req 00000200", rq.size() - nrq); end
    n_checks++; if (dq_pc.size() < 4) begin n_fail++; $display("FAIL b2b_deliv_count: got %0d expected >=4", dq_pc.size()); end
    for (int i = 0; i < dq_pc.size(); i++) begin
      n_checks++; if (dq_pc[i] !== 32'h200 + 32'(4 * i) || dq_instr[i] !== mem_word(32'h200 + 32'(4 * i))) begin
        n_fail++; $display("FAIL b2b_entry[%0d]: got pc %h instr %h expected pc %h", i, dq_pc[i], dq_instr[i], 32'h200 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_error();
    apply_reset();
    err_addr = 32'h8;
    repeat (10) step();
    n_checks++; if (rq.size() < 4 || rq[3] !== 32'hC) begin n_fail++; $display("FAIL err_fetch_continues: got %0d reqs, expected 0000000c at index 3", rq.size()); end
    n_checks++; if (dq_pc.size() < 4) begin n_fail++; $display("FAIL err_deliv_count: got %0d expected >=4", dq_pc.size()); end
    else begin
      n_checks++; if (dq_pc[2] !== 32'h8 || dq_err[2] !== 1'b1) begin n_fail++; $display("FAIL err_entry8: got pc %h ierr %b expected pc 00000008 ierr 1", dq_pc[2], dq_err[2]); end
      n_checks++; if (dq_pc[3] !== 32'hC || dq_err[3] !== 1'b0 || dq_instr[3] !== mem_word(32'hC)) begin
        n_fail++; $display("FAIL err_entryC: got pc %h ierr %b instr %h expected pc 0000000c ierr 0 instr %h", dq_pc[3], dq_err[3], dq_instr[3], mem_word(32'hC));
      end
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    repeat (3) step();
    rsp_en = 1'b0;
    repeat (2) step();
    @(posedge clk); #1;
    resetb = 1'b0;
    #2;
    n_checks++; if (ivalid !== 1'b0 || ipc !== RESET_ADDR || iinstr !== 32'h0 || ierr !== 1'b0) begin
      n_fail++; $display("FAIL midreset_head: got ivalid %b ipc %h iinstr %h ierr %b expected 0/%h/0/0", ivalid, ipc, iinstr, ierr, RESET_ADDR);
    end
    n_checks++; if (treqaddr !== RESET_ADDR || treqvalid !== 1'b0) begin n_fail++; $display("FAIL midreset_req: got treqaddr %h treqvalid %b expected %h/0", treqaddr, treqvalid, RESET_ADDR); end
    @(posedge clk); #1;
    clear_logs();
    resetb = 1'b1; cyc = 0; rsp_en = 1'b1;
    inject_stray = 1'b1;
    step();
    inject_stray = 1'b0;
    repeat (8) step();
    n_checks++; if (dq_pc.size() < 4) begin n_fail++; $display("FAIL midreset_deliv_count: got %0d expected >=4", dq_pc.size()); end
    for (int i = 0; i < dq_pc.size(); i++) begin
      n_checks++; if (dq_pc[i] !== 32'(4 * i) || dq_instr[i] !== mem_word(32'(4 * i))) begin
        n_fail++; $display("FAIL midreset_entry[%0d]: got pc %h instr %h expected pc %h instr %h", i, dq_pc[i], dq_instr[i], 32'(4 * i), mem_word(32'(4 * i)));
      end
    end
  endtask

  task automatic test_random();
    int bad;
    apply_reset();
    rand_ready = 1'b1; rand_iready = 1'b1;
    repeat (300) step();
    rand_ready = 1'b0; rand_iready = 1'b0; treqready = 1'b0; iready = 1'b1;
    repeat (12) step();
    bad = 0;
    n_checks++; if (dq_pc.size() < 50) begin n_fail++; $display("FAIL rand_deliv_count: got %0d expected >=50", dq_pc.size()); end
    n_checks++; if (dq_pc.size() !== rq.size()) begin n_fail++; $display("FAIL rand_no_loss: got %0d delivered expected %0d requested", dq_pc.size(), rq.size()); end
    for (int i = 0; i < dq_pc.size(); i++) begin
      n_checks++; if (dq_pc[i] !== 32'(4 * i) || dq_instr[i] !== mem_word(32'(4 * i))) begin
        n_fail++;
        if (bad < 5) $display("FAIL rand_entry[%0d]: got pc %h instr %h expected pc %h instr %h", i, dq_pc[i], dq_instr[i], 32'(4 * i), mem_word(32'(4 * i)));
        bad++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_jump();
    test_back_to_back_jump();
    test_error();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
